dmem_arbiter: RTL and testbench

//  Two-master arbiter that shares the single dataMemory port between the CPU load/store path (m0)
//  and the debug/program loader (m1). It selects one request per cycle and drives the memory address,

---
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: signal bundle between the two masters, the arbiter and the data memory.
// Modports: slave = arbiter side; master = requesters and memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              m0_req,    m1_req;
    logic              m0_we,     m1_we;
    logic [ADDR_W-1:0] m0_addr,   m1_addr;
    logic [31:0]       m0_wdata,  m1_wdata;
    logic [2:0]        m0_size,   m1_size;
    logic              m0_lock,   m1_lock;
    logic              m0_gnt,    m1_gnt;
    logic              m0_rvalid, m1_rvalid;
    logic [31:0]       m0_rdata,  m1_rdata;

    logic [ADDR_W-1:0] mem_access_addr;
    logic [31:0]       mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic              mem_byte;
    logic              half_word;
    logic              full_word;
    logic              byteU;
    logic              half_wordU;
    logic [31:0]       mem_read_data;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  m0_size, m1_size, m0_lock, m1_lock,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
        output m0_rdata, m1_rdata,
        output mem_access_addr, mem_write_data,
        output mem_write, mem_read,
        output mem_byte, half_word, full_word, byteU, half_wordU,
        input  mem_read_data
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we,
        output m0_addr, m1_addr, m0_wdata, m1_wdata,
        output m0_size, m1_size, m0_lock, m1_lock,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
        input  m0_rdata, m1_rdata,
        input  mem_access_addr, mem_write_data,
        input  mem_write, mem_read,
        input  mem_byte, half_word, full_word, byteU, half_wordU,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with bounded lock sharing one data memory port between
// two masters. Ports: clk, rst_n (async active-low), bus (dmem_arbiter_if.slave).
module dmem_arbiter #(
    parameter int LOCK_MAX = 8,
    parameter int ADDR_W   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    // Counter holds grants already made in the current lock run (1..LOCK_MAX-1).
    localparam int CNT_W = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
    localparam bit LOCK_EN = (LOCK_MAX > 1);

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_owner_q, rd_owner_d;

    logic              gnt0, gnt1, arb_free, any;
    logic              we;
    logic [2:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [4:0]        strb;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        arb_free = 1'b0;
        unique case (state_q)
            LOCK0: begin
                if (bus.m0_req) begin
                    gnt0 = 1'b1;
                    if (bus.m0_lock && cnt_q < CNT_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        last_d  = 1'b0;
                    end
                end else begin
                    arb_free = 1'b1;
                end
            end
            LOCK1: begin
                if (bus.m1_req) begin
                    gnt1 = 1'b1;
                    if (bus.m1_lock && cnt_q < CNT_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        last_d  = 1'b1;
                    end
                end else begin
                    arb_free = 1'b1;
                end
            end
            default: arb_free = 1'b1;
        endcase
        // Lock owner gone quiet: fall back to open arbitration in the same cycle.
        if (arb_free) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (bus.m0_req && (!bus.m1_req || last_q)) begin
                gnt0 = 1'b1;
            end else if (bus.m1_req) begin
                gnt1 = 1'b1;
            end
            if (gnt0) begin
                last_d = 1'b0;
                if (bus.m0_lock && LOCK_EN) begin
                    state_d = LOCK0;
                    cnt_d   = CNT_W'(1);
                end
            end
            if (gnt1) begin
                last_d = 1'b1;
                if (bus.m1_lock && LOCK_EN) begin
                    state_d = LOCK1;
                    cnt_d   = CNT_W'(1);
                end
            end
        end
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign any   = gnt0 | gnt1;
    assign we    = gnt1 ? bus.m1_we    : bus.m0_we;
    assign size  = gnt1 ? bus.m1_size  : bus.m0_size;
    assign addr  = gnt1 ? bus.m1_addr  : bus.m0_addr;
    assign wdata = gnt1 ? bus.m1_wdata : bus.m0_wdata;

    // strb = {byte, half, word, byteU, halfU}
    always_comb begin
        strb = '0;
        if (any) begin
            unique case (size)
                3'b000:  strb = 5'b10000;
                3'b001:  strb = 5'b01000;
                3'b100:  strb = 5'b00010;
                3'b101:  strb = 5'b00001;
                default: strb = 5'b00100;
            endcase
        end
    end

    assign bus.m0_gnt          = gnt0;
    assign bus.m1_gnt          = gnt1;
    assign bus.mem_access_addr = any ? addr : '0;
    assign bus.mem_write_data  = any ? wdata : '0;
    assign bus.mem_write       = any & we;
    assign bus.mem_read        = any & ~we;
    assign bus.mem_byte        = strb[4];
    assign bus.half_word       = strb[3];
    assign bus.full_word       = strb[2];
    assign bus.byteU           = strb[1];
    assign bus.half_wordU      = strb[0];

    assign rd_pend_d  = any & ~we;
    assign rd_owner_d = gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign bus.m0_rvalid = rd_pend_q & ~rd_owner_q;
    assign bus.m1_rvalid = rd_pend_q & rd_owner_q;
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_read_data : '0;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_read_data : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a reference model
// of the arbitration rules, with a small word memory behind the arbiter.
module tb_dmem_arbiter;
    localparam int LOCK_MAX = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32)) bus ();

    dmem_arbiter #(
        .LOCK_MAX(LOCK_MAX),
        .ADDR_W  (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    logic [31:0] mem [0:63];
    int total = 0;
    int bad   = 0;

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_access_addr[7:2]] = bus.mem_write_data;
        if (bus.mem_read) bus.mem_read_data <= mem[bus.mem_access_addr[7:2]];
    end

    // reference model state
    int          mlk, mrun, mlast, mpend;
    logic [31:0] mpend_data;
    int          exp_w;
    logic        exp_rv0, exp_rv1;
    logic [31:0] exp_rd0, exp_rd1;

    function automatic logic [4:0] size_oh(input logic [2:0] s);
        case (s)
            3'b000:  return 5'b10000;
            3'b001:  return 5'b01000;
            3'b100:  return 5'b00010;
            3'b101:  return 5'b00001;
            default: return 5'b00100;
        endcase
    endfunction

    function automatic void model_reset();
        mlk = -1; mrun = 0; mlast = 1; mpend = -1; mpend_data = '0;
    endfunction

    task automatic model_eval();
        logic r[2], l[2], w[2];
        logic [31:0] a;
        r[0] = bus.m0_req;  r[1] = bus.m1_req;
        l[0] = bus.m0_lock; l[1] = bus.m1_lock;
        w[0] = bus.m0_we;   w[1] = bus.m1_we;
        exp_w   = -1;
        exp_rv0 = (mpend == 0);
        exp_rv1 = (mpend == 1);
        exp_rd0 = exp_rv0 ? mpend_data : 32'h0;
        exp_rd1 = exp_rv1 ? mpend_data : 32'h0;
        if (mlk >= 0 && r[mlk]) begin
            exp_w = mlk;
            mrun++;
            if (!l[mlk] || mrun >= LOCK_MAX) mlk = -1;
        end else begin
            mlk = -1;
            if (r[0] && r[1]) exp_w = 1 - mlast;
            else if (r[0]) exp_w = 0;
            else if (r[1]) exp_w = 1;
            if (exp_w >= 0 && l[exp_w] && LOCK_MAX > 1) begin
                mlk = exp_w;
                mrun = 1;
            end
        end
        if (exp_w >= 0) mlast = exp_w;
        if (exp_w >= 0 && !w[exp_w]) begin
            a = (exp_w == 1) ? bus.m1_addr : bus.m0_addr;
            mpend = exp_w;
            mpend_data = mem[a[7:2]];
        end else begin
            mpend = -1;
        end
    endtask

    task automatic idle_inputs();
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m0_size = 0; bus.m0_lock = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        bus.m1_size = 0; bus.m1_lock = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.m0_req = 1; bus.m1_req = 1; bus.m0_size = 3'b010;
        #1;
        total++;
        if ({bus.m1_gnt, bus.m0_gnt} !== 2'b00) begin
            bad++; $display("FAIL reset_gnt: got %b expected 00", {bus.m1_gnt, bus.m0_gnt});
        end
        total++;
        if ({bus.mem_write, bus.mem_read, bus.mem_access_addr, bus.mem_write_data} !== '0) begin
            bad++; $display("FAIL reset_mem: got %b/%b %h %h expected 0", bus.mem_write,
                bus.mem_read, bus.mem_access_addr, bus.mem_write_data);
        end
        total++;
        if ({bus.mem_byte, bus.half_word, bus.full_word, bus.byteU, bus.half_wordU} !== 5'b0) begin
            bad++; $display("FAIL reset_strobe: got nonzero expected 00000");
        end
        total++;
        if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata} !== '0) begin
            bad++; $display("FAIL reset_rvalid: got %b%b expected 00", bus.m0_rvalid, bus.m1_rvalid);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        @(negedge clk);
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h10; bus.m0_size = 3'b010;
        #1;
        total++;
        if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
            bad++; $display("FAIL rd_gnt: got %b expected 01", {bus.m1_gnt, bus.m0_gnt});
        end
        total++;
        if ({bus.mem_read, bus.mem_write, bus.mem_access_addr} !== {2'b10, 32'h10}) begin
            bad++; $display("FAIL rd_bus: got %b%b %h expected 10 00000010", bus.mem_read,
                bus.mem_write, bus.mem_access_addr);
        end
        total++;
        if ({bus.mem_byte, bus.half_word, bus.full_word, bus.byteU, bus.half_wordU} !== 5'b00100) begin
            bad++; $display("FAIL rd_strobe: got %b expected 00100",
                {bus.mem_byte, bus.half_word, bus.full_word, bus.byteU, bus.half_wordU});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++;
        if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata} !== {2'b10, 32'hA500_0004}) begin
            bad++; $display("FAIL rd_data: got %b%b %h expected 10 a5000004", bus.m0_rvalid,
                bus.m1_rvalid, bus.m0_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] eg;
        logic       erv0, erv1;
        logic [31:0] ed;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.m0_req = (k < 4); bus.m0_addr = 32'h40;
            bus.m1_req = (k < 4); bus.m1_addr = 32'h80;
            #1;
            eg = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            total++;
            if ({bus.m1_gnt, bus.m0_gnt} !== eg) begin
                bad++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, {bus.m1_gnt, bus.m0_gnt}, eg);
            end
            if (k > 0) begin
                erv0 = ((k - 1) % 2 == 0);
                erv1 = !erv0;
                ed   = erv0 ? 32'hA500_0010 : 32'hA500_0020;
                total++;
                if ({bus.m0_rvalid, bus.m1_rvalid} !== {erv0, erv1} ||
                    (erv0 ? bus.m0_rdata : bus.m1_rdata) !== ed) begin
                    bad++; $display("FAIL rr_rvalid[%0d]: got %b%b %h/%h expected %b%b %h", k,
                        bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata, erv0, erv1, ed);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        logic [1:0] eg [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            bus.m0_req  = (c >= 1 && c <= 4); bus.m0_addr = 32'h14;
            bus.m1_req  = 1; bus.m1_lock = 1; bus.m1_addr = 32'h84;
            #1;
            total++;
            if ({bus.m1_gnt, bus.m0_gnt} !== eg[c]) begin
                bad++; $display("FAIL lock_gnt[%0d]: got %b expected %b", c,
                    {bus.m1_gnt, bus.m0_gnt}, eg[c]);
            end
            if (c == 5) begin
                total++;
                if ({bus.m0_rvalid, bus.m0_rdata} !== {1'b1, 32'hA500_0005}) begin
                    bad++; $display("FAIL lock_m0_rdata: got %b %h expected 1 a5000005",
                        bus.m0_rvalid, bus.m0_rdata);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_write();
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h21;
        bus.m1_wdata = 32'hAB; bus.m1_size = 3'b000;
        #1;
        total++;
        if ({bus.m1_gnt, bus.mem_write, bus.mem_read, bus.mem_access_addr, bus.mem_write_data}
            !== {3'b110, 32'h21, 32'hAB}) begin
            bad++; $display("FAIL wr_bus: got %b%b%b %h %h expected 110 00000021 000000ab",
                bus.m1_gnt, bus.mem_write, bus.mem_read, bus.mem_access_addr, bus.mem_write_data);
        end
        total++;
        if ({bus.mem_byte, bus.half_word, bus.full_word, bus.byteU, bus.half_wordU} !== 5'b10000) begin
            bad++; $display("FAIL wr_strobe: got %b expected 10000",
                {bus.mem_byte, bus.half_word, bus.full_word, bus.byteU, bus.half_wordU});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++;
        if ({bus.mem_write, bus.m0_rvalid, bus.m1_rvalid, bus.mem_access_addr} !== '0) begin
            bad++; $display("FAIL wr_after: got %b%b%b %h expected 000 0", bus.mem_write,
                bus.m0_rvalid, bus.m1_rvalid, bus.mem_access_addr);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.m0_req = 1; bus.m0_addr = 32'h10; bus.m0_size = 3'b010;
        #1;
        total++;
        if (bus.m0_gnt !== 1'b1) begin
            bad++; $display("FAIL rstmid_gnt: got %b expected 1", bus.m0_gnt);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.m0_rvalid, bus.m0_rdata, bus.m0_gnt, bus.mem_read} !== '0) begin
            bad++; $display("FAIL rstmid_drop: got rv=%b %h gnt=%b rd=%b expected 0",
                bus.m0_rvalid, bus.m0_rdata, bus.m0_gnt, bus.mem_read);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.m1_req = 1; bus.m1_addr = 32'h20;
        #1;
        total++;
        if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
            bad++; $display("FAIL rstmid_tie: got %b expected 01", {bus.m1_gnt, bus.m0_gnt});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_size();
        @(negedge clk);
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_size = 3'b111; bus.m0_addr = 32'h30;
        #1;
        total++;
        if ({bus.mem_byte, bus.half_word, bus.full_word, bus.byteU, bus.half_wordU} !== 5'b00100) begin
            bad++; $display("FAIL size_111: got %b expected 00100",
                {bus.mem_byte, bus.half_word, bus.full_word, bus.byteU, bus.half_wordU});
        end
        @(negedge clk);
        bus.m0_we = 0; bus.m0_size = 3'b101;
        #1;
        total++;
        if ({bus.mem_read, bus.mem_byte, bus.half_word, bus.full_word, bus.byteU, bus.half_wordU}
            !== 6'b100001) begin
            bad++; $display("FAIL size_101: got %b expected 100001", {bus.mem_read, bus.mem_byte,
                bus.half_word, bus.full_word, bus.byteU, bus.half_wordU});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        logic p[2], pw[2], pl[2];
        logic [31:0] pa[2], pd[2];
        logic [2:0] ps[2];
        logic [1:0] eg;
        logic [4:0] e_strb;
        logic [31:0] e_addr, e_data;
        logic e_wr, e_rd;
        do_reset();
        for (int m = 0; m < 2; m++) begin
            p[m] = 0; pw[m] = 0; pl[m] = 0; pa[m] = 0; pd[m] = 0; ps[m] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (!p[m] && $urandom_range(0, 99) < 55) begin
                    p[m]  = 1;
                    pw[m] = ($urandom_range(0, 2) == 0);
                    pl[m] = ($urandom_range(0, 99) < 40);
                    pa[m] = {24'h0, 8'($urandom)};
                    pd[m] = $urandom;
                    ps[m] = 3'($urandom);
                end
            end
            bus.m0_req = p[0]; bus.m0_we = pw[0]; bus.m0_lock = pl[0];
            bus.m0_addr = pa[0]; bus.m0_wdata = pd[0]; bus.m0_size = ps[0];
            bus.m1_req = p[1]; bus.m1_we = pw[1]; bus.m1_lock = pl[1];
            bus.m1_addr = pa[1]; bus.m1_wdata = pd[1]; bus.m1_size = ps[1];
            #1;
            model_eval();
            eg = 2'b00; e_strb = '0; e_addr = '0; e_data = '0; e_wr = 0; e_rd = 0;
            if (exp_w >= 0) begin
                eg[exp_w] = 1'b1;
                e_strb = size_oh(ps[exp_w]);
                e_addr = pa[exp_w];
                e_data = pd[exp_w];
                e_wr = pw[exp_w];
                e_rd = !pw[exp_w];
            end
            total++;
            if ({bus.m1_gnt, bus.m0_gnt} !== eg) begin
                bad++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, {bus.m1_gnt, bus.m0_gnt}, eg);
            end
            total++;
            if ({bus.m0_rvalid, bus.m1_rvalid} !== {exp_rv0, exp_rv1}) begin
                bad++; $display("FAIL rnd_rvalid[%0d]: got %b%b expected %b%b", c,
                    bus.m0_rvalid, bus.m1_rvalid, exp_rv0, exp_rv1);
            end
            total++;
            if (bus.m0_rdata !== exp_rd0 || bus.m1_rdata !== exp_rd1) begin
                bad++; $display("FAIL rnd_rdata[%0d]: got %h/%h expected %h/%h", c,
                    bus.m0_rdata, bus.m1_rdata, exp_rd0, exp_rd1);
            end
            total++;
            if (bus.mem_access_addr !== e_addr || bus.mem_write_data !== e_data) begin
                bad++; $display("FAIL rnd_addr[%0d]: got %h %h expected %h %h", c,
                    bus.mem_access_addr, bus.mem_write_data, e_addr, e_data);
            end
            total++;
            if ({bus.mem_write, bus.mem_read} !== {e_wr, e_rd}) begin
                bad++; $display("FAIL rnd_rw[%0d]: got %b%b expected %b%b", c,
                    bus.mem_write, bus.mem_read, e_wr, e_rd);
            end
            total++;
            if ({bus.mem_byte, bus.half_word, bus.full_word, bus.byteU, bus.half_wordU} !== e_strb) begin
                bad++; $display("FAIL rnd_strobe[%0d]: got %b expected %b", c,
                    {bus.mem_byte, bus.half_word, bus.full_word, bus.byteU, bus.half_wordU}, e_strb);
            end
            if (exp_w >= 0) p[exp_w] = 0;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
        model_reset();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_write();
        test_reset_mid();
        test_size();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
